// File: rtl/seq_add_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// seq_add_ctrl_pkg
//   Shared definitions for the sequential adder/subtractor controller.
//   - SLICE_W   : width of the time-shared carry-lookahead slice (one byte).
//   - state_e   : controller state encoding (IDLE / RUN / DONE).
//   - idx_width : width of the slice index register for a given pass count.
// ---------------------------------------------------------------------------
package seq_add_ctrl_pkg;

  localparam int SLICE_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Bits needed to count 0..n-1; never less than one so a two-pass
  // configuration still gets a real register.
  function automatic int idx_width(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/seq_add_ctrl_cla8.sv
// ---------------------------------------------------------------------------
// seq_add_ctrl_cla8
//   8-bit carry-lookahead adder slice (CLA_8). Purely combinational.
//   Ports:
//     a, b  [7:0] in  : slice operands
//     cin         in  : carry into bit 0
//     sum   [7:0] out : a + b + cin (low 8 bits)
//     g           out : group generate of the slice
//     p           out : group propagate of the slice
//     cout        out : carry out of bit 7 (equal to g | (p & cin))
// ---------------------------------------------------------------------------
module seq_add_ctrl_cla8
  import seq_add_ctrl_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               cin,
  output logic [SLICE_W-1:0] sum,
  output logic               g,
  output logic               p,
  output logic               cout
);

  logic [SLICE_W-1:0] bit_g;
  logic [SLICE_W-1:0] bit_p;

  assign bit_g = a & b;
  assign bit_p = a ^ b;

  // Each bit's carry-in is expressed as the group generate/propagate of the
  // bits below it, so no bit depends on another bit's carry output.
  always_comb begin
    logic grp_g;
    logic grp_p;
    sum   = '0;
    grp_g = 1'b0;
    grp_p = 1'b1;
    for (int i = 0; i < SLICE_W; i++) begin
      sum[i] = bit_p[i] ^ (grp_g | (grp_p & cin));
      grp_g  = bit_g[i] | (bit_p[i] & grp_g);
      grp_p  = grp_p & bit_p[i];
    end
    g    = grp_g;
    p    = grp_p;
    cout = grp_g | (grp_p & cin);
  end

endmodule

// File: rtl/seq_add_ctrl.sv
// ---------------------------------------------------------------------------
// seq_add_ctrl
//   Multi-cycle WIDTH-bit adder/subtractor. One 8-bit CLA slice is reused for
//   WIDTH/8 passes, least-significant byte first, with a carry register
//   linking the passes.
//
//   Build option: define SEQ_ADD_SUB_EN to enable subtraction via op_sub.
//   Without it op_sub is ignored and every operation is an add.
//
//   Parameters:
//     WIDTH      : operand/result width, a multiple of 8 and at least 16.
//   Ports:
//     clock      in  : rising-edge clock
//     reset_n    in  : asynchronous active-low reset
//     start      in  : operation request
//     op_sub     in  : 1 = a - b, 0 = a + b (sampled with start)
//     a, b       in  : operands (sampled with start)
//     busy       out : high while passes are running
//     done       out : one-cycle pulse, result/cout/overflow valid
//     result     out : sum/difference, held until the next accepted start
//     cout       out : carry out of the top bit (for sub: 1 = no borrow)
//     overflow   out : signed overflow of the operation
//     dbg_state  out : current controller state (state_e encoding)
//
//   Handshake: start is accepted on any rising edge where busy is low
//   (IDLE or DONE); a, b and op_sub are captured on that edge and may change
//   freely afterwards. start while busy is high is dropped, not queued.
//   done pulses for one cycle exactly WIDTH/8 edges after acceptance;
//   result, cout and overflow are valid from that cycle onwards.
// ---------------------------------------------------------------------------
module seq_add_ctrl
  import seq_add_ctrl_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic             op_sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow,
  output logic [1:0]       dbg_state
);

  localparam int NUM_SLICES = WIDTH / SLICE_W;
  localparam int IDX_W      = idx_width(NUM_SLICES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SLICES - 1);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               carry_q, carry_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;        // holds b_eff, not raw b
  logic [WIDTH-1:0]   result_q, result_d;
  logic               cout_q, cout_d;
  logic               ovf_q, ovf_d;

  logic [WIDTH-1:0]   b_eff_in;
  logic               cin0;

`ifdef SEQ_ADD_SUB_EN
  assign b_eff_in = op_sub ? ~b : b;
  assign cin0     = op_sub;
`else
  logic op_sub_unused;
  assign op_sub_unused = op_sub;
  assign b_eff_in      = b;
  assign cin0          = 1'b0;
`endif

  // Byte lane selected by the current pass.
  logic [SLICE_W-1:0] slice_a;
  logic [SLICE_W-1:0] slice_b;
  logic [SLICE_W-1:0] slice_sum;
  logic               slice_g;
  logic               slice_p;
  logic               slice_c;
  logic               slice_cout_unused;

  assign slice_a = a_q[int'(idx_q) * SLICE_W +: SLICE_W];
  assign slice_b = b_q[int'(idx_q) * SLICE_W +: SLICE_W];

  seq_add_ctrl_cla8 u_cla8 (
    .a    (slice_a),
    .b    (slice_b),
    .cin  (carry_q),
    .sum  (slice_sum),
    .g    (slice_g),
    .p    (slice_p),
    .cout (slice_cout_unused)
  );

  // The carry linking passes is rebuilt from group G/P rather than taken
  // from the slice's own carry output.
  assign slice_c = slice_g | (slice_p & carry_q);

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    carry_d  = carry_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = RUN;
          a_d     = a;
          b_d     = b_eff_in;
          idx_d   = '0;
          carry_d = cin0;
        end else begin
          state_d = IDLE;
        end
      end

      RUN: begin
        result_d[int'(idx_q) * SLICE_W +: SLICE_W] = slice_sum;
        carry_d = slice_c;
        if (idx_q == LAST_IDX) begin
          state_d = DONE;
          cout_d  = slice_c;
          // On the last pass slice_sum[7] is result bit WIDTH-1.
          ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) &
                    (slice_sum[SLICE_W-1] != a_q[WIDTH-1]);
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      carry_q  <= carry_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
    end
  end

  assign busy      = (state_q == RUN);
  assign done      = (state_q == DONE);
  assign result    = result_q;
  assign cout      = cout_q;
  assign overflow  = ovf_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_seq_add_ctrl.sv
// ---------------------------------------------------------------------------
// tb_seq_add_ctrl
//   Self-checking bench for seq_add_ctrl (WIDTH = 32). Expected results come
//   from plain integer arithmetic on the operands; a monitor pops them when
//   done pulses and also checks latency and busy length.
// ---------------------------------------------------------------------------
module tb_seq_add_ctrl;

  localparam int W  = 32;
  localparam int NS = W / 8;
`ifdef SEQ_ADD_SUB_EN
  localparam bit SUB_EN = 1'b1;
`else
  localparam bit SUB_EN = 1'b0;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic         clock   = 1'b0;
  logic         reset_n = 1'b0;
  logic         start   = 1'b0;
  logic         op_sub  = 1'b0;
  logic [W-1:0] a       = '0;
  logic [W-1:0] b       = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         cout;
  logic         overflow;
  logic [1:0]   dbg_state;

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  seq_add_ctrl #(.WIDTH(W)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .start     (start),
    .op_sub    (op_sub),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .cout      (cout),
    .overflow  (overflow),
    .dbg_state (dbg_state)
  );

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;

  logic [W+1:0] exp_q[$];      // {overflow, cout, result}
  int           exp_cyc_q[$];  // cycle count at which done must be seen
  logic [W-1:0] last_exp_result = '0;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: integer add/sub, unsigned carry and signed range check.
  task automatic push_exp(input logic [W-1:0] ia, input logic [W-1:0] ib,
                          input logic isub, input int when);
    bit              s;
    longint unsigned ua, ub, full;
    longint          sa, sb, sres, max_s, min_s;
    logic [W-1:0]    r;
    logic            c, v;
    s     = isub & SUB_EN;
    ua    = longint'(ia);
    ub    = longint'(ib);
    sa    = longint'($signed(ia));
    sb    = longint'($signed(ib));
    max_s = (64'sd1 <<< (W - 1)) - 64'sd1;
    min_s = -(64'sd1 <<< (W - 1));
    if (s) begin
      r    = ia - ib;
      c    = (ua >= ub);
      sres = sa - sb;
    end else begin
      full = ua + ub;
      r    = full[W-1:0];
      c    = full[W];
      sres = sa + sb;
    end
    v = (sres > max_s) || (sres < min_s);
    exp_q.push_back({v, c, r});
    exp_cyc_q.push_back(when);
    last_exp_result = r;
  endtask

  // ---------------- monitor ----------------
  int           run_len = 0;
  logic [W+1:0] mon_e;
  int           mon_t;

  always @(negedge clock) begin
    if (!reset_n) begin
      run_len = 0;
    end else begin
      if (busy) run_len++;
      if (done) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_done: got done=1, expected no pending op (t=%0t)", $time);
        end else begin
          mon_e = exp_q.pop_front();
          mon_t = exp_cyc_q.pop_front();
          check("result",      64'(result),   64'(mon_e[W-1:0]));
          check("cout",        64'(cout),     64'(mon_e[W]));
          check("overflow",    64'(overflow), 64'(mon_e[W+1]));
          check("latency",     64'(cyc),      64'(mon_t));
          check("busy_cycles", 64'(run_len),  64'(NS));
        end
        run_len = 0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_ready();
    int guard;
    guard = 0;
    @(negedge clock);
    while (busy && guard < 50) begin
      @(negedge clock);
      guard++;
    end
    if (guard >= 50) check("ready_timeout", 64'(1), 64'(0));
  endtask

  // Issue one op; returns at the negedge after the accepting edge with start
  // low and operands scrambled.
  task automatic issue_op(input logic [W-1:0] ia, input logic [W-1:0] ib,
                          input logic isub);
    wait_ready();
    start  = 1'b1;
    a      = ia;
    b      = ib;
    op_sub = isub;
    @(posedge clock);
    #1;
    push_exp(ia, ib, isub, cyc + NS);
    @(negedge clock);
    start  = 1'b0;
    a      = $urandom;
    b      = $urandom;
    op_sub = 1'($urandom_range(0, 1));
  endtask

  // start held high from acceptance through RUN into DONE, operands switched
  // to the second op right after acceptance: the first op must be unaffected
  // and the second accepted straight out of DONE.
  task automatic issue_held(input logic [W-1:0] a1, input logic [W-1:0] b1,
                            input logic [W-1:0] a2, input logic [W-1:0] b2);
    int t1;
    wait_ready();
    start  = 1'b1;
    a      = a1;
    b      = b1;
    op_sub = 1'b0;
    @(posedge clock);
    #1;
    t1 = cyc;
    push_exp(a1, b1, 1'b0, t1 + NS);
    @(negedge clock);
    a = a2;
    b = b2;
    push_exp(a2, b2, 1'b0, t1 + NS + 1 + NS);
    repeat (NS + 1) @(posedge clock);
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (exp_q.size() > 0 && guard < 100) begin
      @(negedge clock);
      guard++;
    end
    check("drain_empty", 64'(exp_q.size()), 64'(0));
  endtask

  function automatic logic [W-1:0] rand_operand();
    logic [W-1:0] v;
    case ($urandom_range(0, 4))
      0:       v = W'($urandom);
      1:       v = {W{1'b1}};
      2:       v = {1'b0, {(W-1){1'b1}}};
      3:       v = {1'b1, {(W-1){1'b0}}};
      default: v = W'($urandom_range(0, 255));
    endcase
    return v;
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_busy",     64'(busy),      64'(0));
    check("rst_done",     64'(done),      64'(0));
    check("rst_result",   64'(result),    64'(0));
    check("rst_cout",     64'(cout),      64'(0));
    check("rst_overflow", 64'(overflow),  64'(0));
    check("rst_state",    64'(dbg_state), 64'(0));
    reset_n = 1'b1;
    @(negedge clock);

    // Directed adds.
    issue_op(32'h0000_00FF, 32'h0000_0001, 1'b0);
    issue_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
    issue_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
`ifdef SEQ_ADD_SUB_EN
    issue_op(32'h0000_0005, 32'h0000_0007, 1'b1);
    issue_op(32'h8000_0000, 32'h0000_0001, 1'b1);
`endif
    drain();

    // start during RUN ignored, start held through DONE accepted.
    issue_held(32'h1234_5678, 32'h1111_1111, 32'hDEAD_BEEF, 32'h2152_4111);
    drain();

    // Reset in the second RUN cycle aborts the op.
    issue_op(32'hAAAA_AAAA, 32'h5555_5555, 1'b0);
    @(posedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    check("abort_busy",     64'(busy),     64'(0));
    check("abort_done",     64'(done),     64'(0));
    check("abort_result",   64'(result),   64'(0));
    check("abort_cout",     64'(cout),     64'(0));
    check("abort_overflow", 64'(overflow), 64'(0));
    exp_q.delete();
    exp_cyc_q.delete();
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    issue_op(32'h0000_0001, 32'h0000_0002, 1'b0);
    drain();

    // Randomized ops with random gaps (gap 0 gives back-to-back issue).
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clock);
      issue_op(rand_operand(), rand_operand(), 1'($urandom_range(0, 1)));
    end
    drain();

    // Result holds while idle.
    repeat (3) @(negedge clock);
    check("result_hold", 64'(result), 64'(last_exp_result));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
